piece_queue: RTL

Next-piece buffer sitting directly downstream of the pseudo-random piece generator in the Tetris datapath. Samples the generator's 3-bit piece code every clock, rejects out-of-range codes and over-long repeats, and holds a short FIFO of upcoming pieces. The game controller pops the head on each spawn; the full queue is exported for the "next piece" preview on the VGA side.

---
 rtl/piece_queue.sv | 113 +++++++++++
 1 files changed

// File: rtl/piece_queue.sv
// Next-piece FIFO behind the random generator: filters illegal codes and long repeats,
// and exposes the whole queue for the preview display.
module piece_queue #(
  parameter int DEPTH      = 3,
  parameter int NUM_PIECES = 5,
  parameter int MAX_REPEAT = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0]                 rand_in,
  input  logic                       spawn_req,
  output logic                       piece_valid,
  output logic [2:0]                 piece_id,
  output logic [3*DEPTH-1:0]         preview,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(MAX_REPEAT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [RW-1:0] MAXREP_C = RW'(MAX_REPEAT);
  localparam logic [3:0]    NUMP_C   = 4'(NUM_PIECES);

  // Encoding chosen so bit 0 is "non-empty" and bit 1 is "full", letting outputs come straight off flops.
  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FILLING = 2'b01,
    FULL    = 2'b11
  } occ_e;

  occ_e          state_r, state_s;
  logic [2:0]    q_r     [DEPTH];
  logic [2:0]    shift_s [DEPTH];
  logic [2:0]    q_s     [DEPTH];
  logic [CW-1:0] count_r, count_s, wr_idx_s;
  logic [2:0]    last_r, last_s;
  logic [RW-1:0] run_r, run_s;
  logic          pop_s, legal_s, rep_block_s, accept_s;

  // Next-state computation: pop/accept decision, shifted queue, write slot and repeat bookkeeping.
  always_comb begin
    pop_s       = spawn_req & state_r[0];
    legal_s     = ({1'b0, rand_in} < NUMP_C);
    rep_block_s = (rand_in == last_r) && (run_r == MAXREP_C);
    accept_s    = legal_s && !rep_block_s && ((count_r != DEPTH_C) || pop_s);
    wr_idx_s    = pop_s ? (count_r - CW'(1)) : count_r;

    for (int i = 0; i < DEPTH - 1; i++) begin
      shift_s[i] = pop_s ? q_r[i+1] : q_r[i];
    end
    shift_s[DEPTH-1] = pop_s ? 3'd0 : q_r[DEPTH-1];

    for (int i = 0; i < DEPTH; i++) begin
      q_s[i] = (accept_s && (wr_idx_s == CW'(i))) ? rand_in : shift_s[i];
    end

    case ({accept_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase

    // Repeat tracking follows pushes only; pops leave it untouched.
    if (accept_s) begin
      last_s = rand_in;
      run_s  = (rand_in == last_r) ? (run_r + RW'(1)) : RW'(1);
    end else begin
      last_s = last_r;
      run_s  = run_r;
    end

    if (count_s == {CW{1'b0}}) begin
      state_s = EMPTY;
    end else if (count_s == DEPTH_C) begin
      state_s = FULL;
    end else begin
      state_s = FILLING;
    end
  end

  // State register with synchronous clear of queue, occupancy and repeat history.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= EMPTY;
      count_r <= {CW{1'b0}};
      last_r  <= 3'd7;
      run_r   <= {RW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i] <= 3'd0;
      end
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      last_r  <= last_s;
      run_r   <= run_s;
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i] <= q_s[i];
      end
    end
  end

  assign piece_valid = state_r[0];
  assign full        = state_r[1];
  assign count       = count_r;
  assign piece_id    = q_r[0];

  // Vacated slots are always cleared, so unoccupied preview entries naturally read 0.
  for (genvar g = 0; g < DEPTH; g++) begin : g_preview
    assign preview[3*g +: 3] = q_r[g];
  end

endmodule
